// File: rtl/rv_warp_ctl_handler.sv
// Warp-scheduler side of the warp-control interface: per-warp active/tmask state,
// barrier stalls, IPDOM split/join stacks, spawn requests and join PC redirects.
module rv_warp_ctl_handler #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_THREADS  = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int STACK_DEPTH  = 4,
  localparam int NW_BITS = $clog2(NUM_WARPS),
  localparam int NB_BITS = $clog2(NUM_BARRIERS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             warp_ctl_if_valid,
  input  logic [NW_BITS-1:0]               warp_ctl_if_wid,
  input  logic                             warp_ctl_if_tmc_valid,
  input  logic [NUM_THREADS-1:0]           warp_ctl_if_tmc_tmask,
  input  logic                             warp_ctl_if_wspawn_valid,
  input  logic [NUM_WARPS-1:0]             warp_ctl_if_wspawn_wmask,
  input  logic [31:0]                      warp_ctl_if_wspawn_pc,
  input  logic                             warp_ctl_if_split_valid,
  input  logic                             warp_ctl_if_split_diverged,
  input  logic [NUM_THREADS-1:0]           warp_ctl_if_split_then_tmask,
  input  logic [NUM_THREADS-1:0]           warp_ctl_if_split_else_tmask,
  input  logic [31:0]                      warp_ctl_if_split_pc,
  input  logic                             warp_ctl_if_barrier_valid,
  input  logic [NB_BITS-1:0]               warp_ctl_if_barrier_id,
  input  logic [NW_BITS-1:0]               warp_ctl_if_barrier_size_m1,
  input  logic                             join_valid,
  input  logic [NW_BITS-1:0]               join_wid,
  output logic                             join_ready,
  output logic [NUM_WARPS-1:0]             warp_active,
  output logic [NUM_WARPS-1:0]             warp_stalled,
  output logic [NUM_WARPS*NUM_THREADS-1:0] warp_tmask,
  output logic                             spawn_valid,
  output logic [NUM_WARPS-1:0]             spawn_wmask,
  output logic [31:0]                      spawn_pc,
  output logic                             join_redirect_valid,
  output logic [NW_BITS-1:0]               join_redirect_wid,
  output logic [31:0]                      join_redirect_pc,
  output logic                             stack_error
);

  localparam int SP_BITS = $clog2(STACK_DEPTH + 1);
  localparam int SI_BITS = $clog2(STACK_DEPTH);

  logic [NUM_WARPS-1:0]   active;
  logic [NUM_WARPS-1:0]   stalled;
  logic [NUM_THREADS-1:0] tmask    [NUM_WARPS];
  logic [NW_BITS-1:0]     bar_cnt  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]   bar_mask [NUM_BARRIERS];
  logic                   stk_ft   [NUM_WARPS][STACK_DEPTH];
  logic [NUM_THREADS-1:0] stk_tm   [NUM_WARPS][STACK_DEPTH];
  logic [31:0]            stk_pc   [NUM_WARPS][STACK_DEPTH];
  logic [SP_BITS-1:0]     sp       [NUM_WARPS];

  logic                 do_tmc, do_wspawn, do_split, do_bar;
  logic [NUM_WARPS-1:0] spawn_fmask;
  logic                 split_room;
  logic [SI_BITS-1:0]   push_idx, push_idx1, pop_idx;
  logic [SP_BITS-1:0]   sp_m1;
  logic                 join_fire, join_empty;

  // Only the highest-priority sub-valid of an event is honoured.
  always_comb begin
    do_tmc    = warp_ctl_if_valid && warp_ctl_if_tmc_valid;
    do_wspawn = warp_ctl_if_valid && !warp_ctl_if_tmc_valid && warp_ctl_if_wspawn_valid;
    do_split  = warp_ctl_if_valid && !warp_ctl_if_tmc_valid && !warp_ctl_if_wspawn_valid &&
                warp_ctl_if_split_valid;
    do_bar    = warp_ctl_if_valid && !warp_ctl_if_tmc_valid && !warp_ctl_if_wspawn_valid &&
                !warp_ctl_if_split_valid && warp_ctl_if_barrier_valid;
    spawn_fmask = '0;
    for (int j = 0; j < NUM_WARPS; j++) begin
      spawn_fmask[j] = warp_ctl_if_wspawn_wmask[j] && !active[j] &&
                       (NW_BITS'(j) != warp_ctl_if_wid);
    end
    split_room = (int'(sp[warp_ctl_if_wid]) + (warp_ctl_if_split_diverged ? 2 : 1))
                 <= STACK_DEPTH;
    push_idx   = sp[warp_ctl_if_wid][SI_BITS-1:0];
    push_idx1  = push_idx + SI_BITS'(1);
    join_ready = !(warp_ctl_if_valid && (warp_ctl_if_wid == join_wid));
    join_fire  = join_valid && join_ready;
    join_empty = (sp[join_wid] == '0);
    sp_m1      = sp[join_wid] - SP_BITS'(1);
    pop_idx    = sp_m1[SI_BITS-1:0];
  end

  // Join and warp_ctl updates never target the same warp (join_ready), so both can land.
  always_ff @(posedge clk) begin
    if (reset) begin
      active              <= NUM_WARPS'(1);
      stalled             <= '0;
      spawn_valid         <= 1'b0;
      spawn_wmask         <= '0;
      spawn_pc            <= '0;
      join_redirect_valid <= 1'b0;
      join_redirect_wid   <= '0;
      join_redirect_pc    <= '0;
      stack_error         <= 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        tmask[w] <= (w == 0) ? NUM_THREADS'(1) : '0;
        sp[w]    <= '0;
      end
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        bar_cnt[b]  <= '0;
        bar_mask[b] <= '0;
      end
    end else begin
      spawn_valid         <= 1'b0;
      join_redirect_valid <= 1'b0;

      if (join_fire) begin
        if (join_empty) begin
          stack_error <= 1'b1;
        end else begin
          sp[join_wid]    <= sp_m1;
          tmask[join_wid] <= stk_tm[join_wid][pop_idx];
          if (!stk_ft[join_wid][pop_idx]) begin
            join_redirect_valid <= 1'b1;
            join_redirect_wid   <= join_wid;
            join_redirect_pc    <= stk_pc[join_wid][pop_idx];
          end
        end
      end

      if (do_tmc) begin
        tmask[warp_ctl_if_wid] <= warp_ctl_if_tmc_tmask;
        if (warp_ctl_if_tmc_tmask == '0) active[warp_ctl_if_wid] <= 1'b0;
      end

      if (do_wspawn) begin
        for (int j = 0; j < NUM_WARPS; j++) begin
          if (spawn_fmask[j]) begin
            active[j] <= 1'b1;
            tmask[j]  <= NUM_THREADS'(1);
          end
        end
        spawn_valid <= 1'b1;
        spawn_wmask <= spawn_fmask;
        spawn_pc    <= warp_ctl_if_wspawn_pc;
      end

      if (do_split) begin
        if (!split_room) begin
          stack_error <= 1'b1;
        end else begin
          stk_ft[warp_ctl_if_wid][push_idx] <= 1'b1;
          stk_tm[warp_ctl_if_wid][push_idx] <= tmask[warp_ctl_if_wid];
          stk_pc[warp_ctl_if_wid][push_idx] <= '0;
          if (warp_ctl_if_split_diverged) begin
            stk_ft[warp_ctl_if_wid][push_idx1] <= 1'b0;
            stk_tm[warp_ctl_if_wid][push_idx1] <= warp_ctl_if_split_else_tmask;
            stk_pc[warp_ctl_if_wid][push_idx1] <= warp_ctl_if_split_pc;
            sp[warp_ctl_if_wid]    <= sp[warp_ctl_if_wid] + SP_BITS'(2);
            tmask[warp_ctl_if_wid] <= warp_ctl_if_split_then_tmask;
          end else begin
            sp[warp_ctl_if_wid] <= sp[warp_ctl_if_wid] + SP_BITS'(1);
          end
        end
      end

      if (do_bar) begin
        if (bar_cnt[warp_ctl_if_barrier_id] == warp_ctl_if_barrier_size_m1) begin
          bar_cnt[warp_ctl_if_barrier_id]  <= '0;
          bar_mask[warp_ctl_if_barrier_id] <= '0;
          stalled <= stalled & ~bar_mask[warp_ctl_if_barrier_id];
        end else begin
          bar_cnt[warp_ctl_if_barrier_id] <= bar_cnt[warp_ctl_if_barrier_id] + NW_BITS'(1);
          bar_mask[warp_ctl_if_barrier_id][warp_ctl_if_wid] <= 1'b1;
          stalled[warp_ctl_if_wid] <= 1'b1;
        end
      end
    end
  end

  assign warp_active  = active;
  assign warp_stalled = stalled;
  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_tmask
    assign warp_tmask[w*NUM_THREADS +: NUM_THREADS] = tmask[w];
  end

endmodule

// File: tb/tb_rv_warp_ctl_handler.sv
// Directed bench for rv_warp_ctl_handler: state checks after each event, plus a
// scoreboard for the spawn and join-redirect pulses.
module tb_rv_warp_ctl_handler;
  localparam int NW = 4;
  localparam int NT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          warp_ctl_if_valid;
  logic [1:0]    warp_ctl_if_wid;
  logic          warp_ctl_if_tmc_valid;
  logic [NT-1:0] warp_ctl_if_tmc_tmask;
  logic          warp_ctl_if_wspawn_valid;
  logic [NW-1:0] warp_ctl_if_wspawn_wmask;
  logic [31:0]   warp_ctl_if_wspawn_pc;
  logic          warp_ctl_if_split_valid;
  logic          warp_ctl_if_split_diverged;
  logic [NT-1:0] warp_ctl_if_split_then_tmask;
  logic [NT-1:0] warp_ctl_if_split_else_tmask;
  logic [31:0]   warp_ctl_if_split_pc;
  logic          warp_ctl_if_barrier_valid;
  logic [1:0]    warp_ctl_if_barrier_id;
  logic [1:0]    warp_ctl_if_barrier_size_m1;
  logic          join_valid;
  logic [1:0]    join_wid;
  logic          join_ready;
  logic [NW-1:0] warp_active;
  logic [NW-1:0] warp_stalled;
  logic [NW*NT-1:0] warp_tmask;
  logic          spawn_valid;
  logic [NW-1:0] spawn_wmask;
  logic [31:0]   spawn_pc;
  logic          join_redirect_valid;
  logic [1:0]    join_redirect_wid;
  logic [31:0]   join_redirect_pc;
  logic          stack_error;

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_spawn_q[$];
  logic [33:0] exp_redir_q[$];

  always #5 clk = ~clk;

  rv_warp_ctl_handler dut (
    .clk(clk), .reset(reset),
    .warp_ctl_if_valid(warp_ctl_if_valid), .warp_ctl_if_wid(warp_ctl_if_wid),
    .warp_ctl_if_tmc_valid(warp_ctl_if_tmc_valid), .warp_ctl_if_tmc_tmask(warp_ctl_if_tmc_tmask),
    .warp_ctl_if_wspawn_valid(warp_ctl_if_wspawn_valid),
    .warp_ctl_if_wspawn_wmask(warp_ctl_if_wspawn_wmask),
    .warp_ctl_if_wspawn_pc(warp_ctl_if_wspawn_pc),
    .warp_ctl_if_split_valid(warp_ctl_if_split_valid),
    .warp_ctl_if_split_diverged(warp_ctl_if_split_diverged),
    .warp_ctl_if_split_then_tmask(warp_ctl_if_split_then_tmask),
    .warp_ctl_if_split_else_tmask(warp_ctl_if_split_else_tmask),
    .warp_ctl_if_split_pc(warp_ctl_if_split_pc),
    .warp_ctl_if_barrier_valid(warp_ctl_if_barrier_valid),
    .warp_ctl_if_barrier_id(warp_ctl_if_barrier_id),
    .warp_ctl_if_barrier_size_m1(warp_ctl_if_barrier_size_m1),
    .join_valid(join_valid), .join_wid(join_wid), .join_ready(join_ready),
    .warp_active(warp_active), .warp_stalled(warp_stalled), .warp_tmask(warp_tmask),
    .spawn_valid(spawn_valid), .spawn_wmask(spawn_wmask), .spawn_pc(spawn_pc),
    .join_redirect_valid(join_redirect_valid), .join_redirect_wid(join_redirect_wid),
    .join_redirect_pc(join_redirect_pc), .stack_error(stack_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    warp_ctl_if_valid = 0; warp_ctl_if_wid = 0;
    warp_ctl_if_tmc_valid = 0; warp_ctl_if_tmc_tmask = 0;
    warp_ctl_if_wspawn_valid = 0; warp_ctl_if_wspawn_wmask = 0; warp_ctl_if_wspawn_pc = 0;
    warp_ctl_if_split_valid = 0; warp_ctl_if_split_diverged = 0;
    warp_ctl_if_split_then_tmask = 0; warp_ctl_if_split_else_tmask = 0; warp_ctl_if_split_pc = 0;
    warp_ctl_if_barrier_valid = 0; warp_ctl_if_barrier_id = 0; warp_ctl_if_barrier_size_m1 = 0;
    join_valid = 0; join_wid = 0;
  endtask

  // Each driver presents one event for one cycle and returns at the negedge after it lands.
  task automatic finish_cycle();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic do_tmc(input logic [1:0] wid, input logic [NT-1:0] m);
    @(negedge clk);
    warp_ctl_if_valid = 1; warp_ctl_if_wid = wid;
    warp_ctl_if_tmc_valid = 1; warp_ctl_if_tmc_tmask = m;
    finish_cycle();
  endtask

  task automatic do_wspawn(input logic [1:0] wid, input logic [NW-1:0] m, input logic [31:0] pc);
    @(negedge clk);
    warp_ctl_if_valid = 1; warp_ctl_if_wid = wid;
    warp_ctl_if_wspawn_valid = 1; warp_ctl_if_wspawn_wmask = m; warp_ctl_if_wspawn_pc = pc;
    finish_cycle();
  endtask

  task automatic do_split(input logic [1:0] wid, input logic div, input logic [NT-1:0] tm,
                          input logic [NT-1:0] em, input logic [31:0] pc);
    @(negedge clk);
    warp_ctl_if_valid = 1; warp_ctl_if_wid = wid;
    warp_ctl_if_split_valid = 1; warp_ctl_if_split_diverged = div;
    warp_ctl_if_split_then_tmask = tm; warp_ctl_if_split_else_tmask = em;
    warp_ctl_if_split_pc = pc;
    finish_cycle();
  endtask

  task automatic do_bar(input logic [1:0] wid, input logic [1:0] id, input logic [1:0] sm1);
    @(negedge clk);
    warp_ctl_if_valid = 1; warp_ctl_if_wid = wid;
    warp_ctl_if_barrier_valid = 1; warp_ctl_if_barrier_id = id;
    warp_ctl_if_barrier_size_m1 = sm1;
    finish_cycle();
  endtask

  task automatic do_join(input logic [1:0] wid);
    @(negedge clk);
    join_valid = 1; join_wid = wid;
    finish_cycle();
  endtask

  // Scoreboard monitor for the two pulse outputs.
  always @(negedge clk) begin : monitor
    logic [35:0] e_s;
    logic [33:0] e_r;
    if (!reset) begin
      if (spawn_valid) begin
        checks++;
        if (exp_spawn_q.size() == 0) begin
          errors++;
          $display("FAIL spawn_unexpected: got mask %b pc %h, expected no spawn", spawn_wmask, spawn_pc);
        end else begin
          e_s = exp_spawn_q.pop_front();
          if ({spawn_wmask, spawn_pc} !== e_s) begin
            errors++;
            $display("FAIL spawn: got %h expected %h", {spawn_wmask, spawn_pc}, e_s);
          end
        end
      end
      if (join_redirect_valid) begin
        checks++;
        if (exp_redir_q.size() == 0) begin
          errors++;
          $display("FAIL redirect_unexpected: got wid %0d pc %h, expected no redirect",
                   join_redirect_wid, join_redirect_pc);
        end else begin
          e_r = exp_redir_q.pop_front();
          if ({join_redirect_wid, join_redirect_pc} !== e_r) begin
            errors++;
            $display("FAIL redirect: got %h expected %h", {join_redirect_wid, join_redirect_pc}, e_r);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_active"}, 32'(warp_active), 32'h1);
    check({tag, "_tmask"}, 32'(warp_tmask), 32'h0001);
    check({tag, "_stalled"}, 32'(warp_stalled), 32'h0);
    check({tag, "_err"}, 32'(stack_error), 32'h0);
    check({tag, "_spawn_v"}, 32'(spawn_valid), 32'h0);
    check({tag, "_redir_v"}, 32'(join_redirect_valid), 32'h0);
    check({tag, "_join_ready"}, 32'(join_ready), 32'h1);
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    do_reset();
    check_reset_state("reset");

    // Spawn: wid0 excluded, all others inactive.
    exp_spawn_q.push_back({4'b1110, 32'h8000_0100});
    do_wspawn(2'd0, 4'b1111, 32'h8000_0100);
    check("spawn_active", 32'(warp_active), 32'hF);
    check("spawn_tmask", 32'(warp_tmask), 32'h1111);
    // All warps already active: empty mask still pulses.
    exp_spawn_q.push_back({4'b0000, 32'h0000_0400});
    do_wspawn(2'd1, 4'b1111, 32'h0000_0400);
    check("spawn0_active", 32'(warp_active), 32'hF);

    do_tmc(2'd0, 4'b1111);
    check("tmc_full", 32'(warp_tmask), 32'h111F);
    do_tmc(2'd0, 4'b0000);
    check("tmc_zero_active", 32'(warp_active), 32'hE);
    check("tmc_zero_tmask", 32'(warp_tmask), 32'h1110);

    do_bar(2'd1, 2'd2, 2'd2);
    check("bar_w1", 32'(warp_stalled), 32'h2);
    do_bar(2'd2, 2'd2, 2'd2);
    check("bar_w2", 32'(warp_stalled), 32'h6);
    do_bar(2'd3, 2'd2, 2'd2);
    check("bar_release", 32'(warp_stalled), 32'h0);
    // Counter restarted at 0: a 2-warp barrier needs two arrivals.
    do_bar(2'd1, 2'd2, 2'd1);
    check("bar_cnt_reset", 32'(warp_stalled), 32'h2);
    do_bar(2'd2, 2'd2, 2'd1);
    check("bar_release2", 32'(warp_stalled), 32'h0);
    do_bar(2'd3, 2'd1, 2'd0);
    check("bar_size1", 32'(warp_stalled), 32'h0);

    do_tmc(2'd1, 4'b1111);
    check("tmc_w1", 32'(warp_tmask), 32'h11F0);
    do_split(2'd1, 1'b1, 4'b0011, 4'b1100, 32'h0000_0200);
    check("split_then", 32'(warp_tmask), 32'h1130);
    exp_redir_q.push_back({2'd1, 32'h0000_0200});
    do_join(2'd1);
    check("join_else", 32'(warp_tmask), 32'h11C0);
    do_join(2'd1);
    check("join_ft", 32'(warp_tmask), 32'h11F0);
    check("join_ft_err", 32'(stack_error), 32'h0);
    do_join(2'd1);
    check("join_empty_err", 32'(stack_error), 32'h1);
    check("join_empty_tmask", 32'(warp_tmask), 32'h11F0);

    // Reset while a warp is stalled discards barrier state.
    do_bar(2'd2, 2'd0, 2'd3);
    check("pre_reset_stall", 32'(warp_stalled), 32'h4);
    do_reset();
    check_reset_state("midreset");
    do_bar(2'd1, 2'd0, 2'd1);
    check("post_reset_bar", 32'(warp_stalled), 32'h2);

    // Diverged split needs two slots; only one remains.
    do_reset();
    do_split(2'd0, 1'b0, 4'b0000, 4'b0000, 32'h0);
    do_split(2'd0, 1'b1, 4'b0001, 4'b0000, 32'h0000_0300);
    check("div_ok_err", 32'(stack_error), 32'h0);
    do_split(2'd0, 1'b1, 4'b0000, 4'b0001, 32'h0000_0500);
    check("div_ovf_err", 32'(stack_error), 32'h1);
    check("div_ovf_tmask", 32'(warp_tmask), 32'h0001);
    exp_redir_q.push_back({2'd0, 32'h0000_0300});
    do_join(2'd0);
    check("div_ovf_pop", 32'(warp_tmask), 32'h0000);

    do_reset();
    for (int i = 0; i < 4; i++) do_split(2'd0, 1'b0, 4'b0000, 4'b0000, 32'h0);
    check("fill_err", 32'(stack_error), 32'h0);
    do_split(2'd0, 1'b0, 4'b0000, 4'b0000, 32'h0);
    check("ovf_err", 32'(stack_error), 32'h1);
    check("ovf_tmask", 32'(warp_tmask), 32'h0001);

    // Same-warp join is blocked; different-warp join and event both apply.
    do_reset();
    @(negedge clk);
    warp_ctl_if_valid = 1; warp_ctl_if_wid = 2'd2;
    warp_ctl_if_tmc_valid = 1; warp_ctl_if_tmc_tmask = 4'b0000;
    join_valid = 1; join_wid = 2'd2;
    #1 check("join_ready_same", 32'(join_ready), 32'h0);
    finish_cycle();
    check("blocked_join_err", 32'(stack_error), 32'h0);
    @(negedge clk);
    warp_ctl_if_valid = 1; warp_ctl_if_wid = 2'd2;
    warp_ctl_if_tmc_valid = 1; warp_ctl_if_tmc_tmask = 4'b0011;
    join_valid = 1; join_wid = 2'd3;
    #1 check("join_ready_diff", 32'(join_ready), 32'h1);
    finish_cycle();
    check("both_tmc", 32'(warp_tmask), 32'h0301);
    check("both_join_err", 32'(stack_error), 32'h1);

    repeat (2) @(negedge clk);
    check("spawn_q_empty", 32'(exp_spawn_q.size()), 32'h0);
    check("redir_q_empty", 32'(exp_redir_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_warp_ctl_handler.md
Name: rv_warp_ctl_handler

Overview:
- Receiving end of the warp-control interface driven by the GPU execute unit, located in the warp scheduler.
- Owns per-warp state: active bits, thread masks, barrier stalls and the per-warp IPDOM split/join stack.
- Turns each committed warp_ctl_if event (TMC, WSPAWN, SPLIT, BAR) into state updates, spawn requests and join PC redirects for the fetch/PC logic.

Parameters:
- NUM_WARPS, 4, warps per core (matches `NUM_WARPS); NW_BITS = clog2(NUM_WARPS).
- NUM_THREADS, 4, threads per warp (matches `NUM_THREADS).
- NUM_BARRIERS, 4, barrier IDs; NB_BITS = clog2(NUM_BARRIERS).
- STACK_DEPTH, 4, IPDOM entries per warp.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- warp_ctl_if_valid  in  1  committed warp-control event. No backpressure: consumed every valid cycle.
- warp_ctl_if_wid  in  NW_BITS  issuing warp.
- warp_ctl_if_tmc_valid / _tmc_tmask  in  1 / NUM_THREADS  thread-mask change.
- warp_ctl_if_wspawn_valid / _wspawn_wmask / _wspawn_pc  in  1 / NUM_WARPS / 32  warp spawn.
- warp_ctl_if_split_valid / _split_diverged / _split_then_tmask / _split_else_tmask / _split_pc  in  1 / 1 / NUM_THREADS / NUM_THREADS / 32  split.
- warp_ctl_if_barrier_valid / _barrier_id / _barrier_size_m1  in  1 / NB_BITS / NW_BITS  barrier arrival.
- join_valid  in  1  join instruction issued.
- join_wid  in  NW_BITS  joining warp.
- join_ready  out  1  = ~(warp_ctl_if_valid && warp_ctl_if_wid==join_wid).
- warp_active  out  NUM_WARPS  active warps.
- warp_stalled  out  NUM_WARPS  warps held at a barrier.
- warp_tmask  out  NUM_WARPS*NUM_THREADS  per-warp thread masks; warp w occupies bits [(w+1)*NT-1 : w*NT].
- spawn_valid / spawn_wmask / spawn_pc  out  1 / NUM_WARPS / 32  registered spawn request.
- join_redirect_valid / join_redirect_wid / join_redirect_pc  out  1 / NW_BITS / 32  registered PC redirect.
- stack_error  out  1  sticky flag for overflow or underflow.

Behaviour:
- Reset values:
  - warp_active = 1, warp 0 only.
  - warp_tmask: warp 0 = 1 (thread 0 only); all other warps = 0.
  - warp_stalled = 0; all barrier counters and masks = 0; all stacks empty.
  - spawn_*, join_redirect_* and stack_error = 0.
  - Reset mid-operation discards all pending state.
- All state updates take effect the cycle after warp_ctl_if_valid. Pulse outputs (spawn_valid, join_redirect_valid) are high for exactly one cycle.
- Sub-valid priority: exactly one sub-valid is expected per event. If several are set, only the highest applies: tmc > wspawn > split > barrier.
- TMC:
  - tmask[wid] <= tmc_tmask.
  - If tmc_tmask == 0, active[wid] <= 0 and tmask[wid] is cleared.
- WSPAWN:
  - For each j with wmask[j] && !active[j] && j != wid: active[j] <= 1, tmask[j] <= 1.
  - spawn_valid <= 1, spawn_wmask <= that filtered mask, spawn_pc <= wspawn_pc.
  - An all-zero filtered mask still pulses spawn_valid, with mask 0.
- BAR:
  - If count[id] == size_m1 (release): count[id] <= 0, warp_stalled &= ~bar_mask[id], bar_mask[id] <= 0. The arriving warp never stalls. size_m1 == 0 releases immediately.
  - Otherwise: count[id] += 1, bar_mask[id][wid] <= 1, warp_stalled[wid] <= 1.
  - Counters are NW_BITS wide. Arrival of an already-stalled warp is illegal and not checked.
- SPLIT, diverged:
  - Push two entries onto stack[wid]: first {fallthrough=1, tmask=tmask[wid], pc=0}, then {fallthrough=0, tmask=else_tmask, pc=split_pc}.
  - tmask[wid] <= then_tmask.
- SPLIT, not diverged: push one fallthrough entry {1, tmask[wid], 0}; tmask is unchanged.
- Stack overflow: if the stack lacks room for the required entries, no push happens, masks are unchanged and stack_error <= 1.
- JOIN (join_valid && join_ready):
  - Pop the top of stack[join_wid].
  - Else entry (fallthrough=0): tmask <= entry.tmask; join_redirect_valid <= 1 with join_wid and entry.pc.
  - Fallthrough entry: tmask <= entry.tmask; no redirect.
  - Empty stack: ignored, stack_error <= 1.
- A join and a warp_ctl event on different warps in the same cycle are both applied. On the same warp, join_ready = 0, so the join must be held by its source.
- stack_error stays set until reset.

Test Plan:
- Reset, idle -> warp_active=0001, warp_tmask[0]=0001, warp_stalled=0, stack_error=0.
- WSPAWN wid0, wmask=1111, pc=0x80000100 -> next cycle spawn_valid=1, spawn_wmask=1110, spawn_pc=0x80000100; warp_active=1111; tmask[1..3]=0001.
- TMC wid0 tmask=1111, then TMC wid0 tmask=0000 -> tmask[0]=1111, then warp_active[0]=0.
- BAR id2 size_m1=2: warps 1 and 2 arrive -> warp_stalled=0110; warp 3 arrives -> warp_stalled=0000 next cycle and count[2]=0.
- SPLIT wid1 diverged, tmask=1111, then=0011, else=1100, pc=0x200 -> tmask[1]=0011. JOIN -> redirect pc=0x200, tmask=1100. JOIN -> tmask=1111 with no redirect.
- JOIN on an empty stack, and STACK_DEPTH+1 non-diverged splits -> stack_error=1, masks unchanged. Same-cycle warp_ctl and join on the same wid -> join_ready=0.
